// File: rtl/mcycle_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: state and op
// encodings plus the iteration-counter width.
package mcycle_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    // The counter must be able to hold WIDTH itself, hence the +1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/mcycle_unit.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) unit with a
// Start/done 4-phase handshake. One WIDTH+1-bit adder is shared by both ops.
module mcycle_unit
    import mcycle_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // hi/lo hold {product hi, multiplier} for MUL and {remainder, quotient} for DIV.
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    // Multiplicand for MUL, divisor for DIV.
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] res1_q, res1_d;
    logic [WIDTH-1:0] res2_q, res2_d;

    logic [WIDTH:0]   add_a, add_b, sum;
    logic             add_cin;
    logic [WIDTH:0]   mul_acc;
    logic             borrow;
    logic [WIDTH-1:0] hi_step, lo_step;

    // Shared adder: MUL adds the multiplicand to hi; DIV subtracts the divisor
    // from the shifted remainder via two's complement (invert + carry-in).
    always_comb begin
        if (op_q == OP_MUL) begin
            add_a   = {1'b0, hi_q};
            add_b   = {1'b0, opnd_q};
            add_cin = 1'b0;
        end else begin
            add_a   = {hi_q, lo_q[WIDTH-1]};
            add_b   = ~{1'b0, opnd_q};
            add_cin = 1'b1;
        end
        sum = add_a + add_b + {{WIDTH{1'b0}}, add_cin};
    end

    // One iteration of either algorithm, derived from the shared sum.
    always_comb begin
        mul_acc = '0;
        borrow  = 1'b0;
        hi_step = hi_q;
        lo_step = lo_q;
        if (op_q == OP_MUL) begin
            mul_acc = lo_q[0] ? sum : {1'b0, hi_q};
            hi_step = mul_acc[WIDTH:1];
            lo_step = {mul_acc[0], lo_q[WIDTH-1:1]};
        end else begin
            // Shifted remainder < 2*divisor, so the MSB of the WIDTH+1-bit trial is the borrow.
            borrow  = sum[WIDTH];
            hi_step = borrow ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} : sum[WIDTH-1:0];
            lo_step = {lo_q[WIDTH-2:0], ~borrow};
        end
    end

    // NOTE: every signal gets its hold value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        res1_d  = res1_q;
        res2_d  = res2_q;

        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    op_d    = op_e'(MCycleOp);
                    opnd_d  = (op_e'(MCycleOp) == OP_MUL) ? Operand1 : Operand2;
                    lo_d    = (op_e'(MCycleOp) == OP_MUL) ? Operand2 : Operand1;
                    hi_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!Start) begin
                    state_d = ST_IDLE;
                end else begin
                    hi_d  = hi_step;
                    lo_d  = lo_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        res1_d  = lo_step;
                        res2_d  = hi_step;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!Start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MUL;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            res1_q  <= '0;
            res2_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            res1_q  <= res1_d;
            res2_q  <= res2_d;
        end
    end

    assign Result1 = res1_q;
    assign Result2 = res2_q;
    assign Busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed bench for mcycle_unit: reset, latency, mul/div corner cases,
// handshake, abort, operand isolation and a short reference-model sweep.
module tb_mcycle_unit;

    logic        CLK = 1'b0;
    logic        rst;
    logic        Start;
    logic        MCycleOp;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [31:0] Result1;
    logic [31:0] Result2;
    logic        Busy;
    logic        done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mcycle_unit #(.WIDTH(32)) dut (
        .CLK      (CLK),
        .rst      (rst),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy),
        .done     (done)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Raises Start with the given op; cycles counts edges from the sampling edge
    // (inclusive) to the first edge after which done is seen. Drops Start afterwards.
    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles, output int busy_cycles, output bit timed_out);
        MCycleOp    = op;
        Operand1    = a;
        Operand2    = b;
        Start       = 1'b1;
        cycles      = 0;
        busy_cycles = 0;
        timed_out   = 1'b0;
        while (1) begin
            tick();
            cycles++;
            if (Busy) busy_cycles++;
            if (done) break;
            if (cycles >= 40) begin
                timed_out = 1'b1;
                break;
            end
        end
        Start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int  cyc, bsy;
        bit  to;
        rst      = 1'b1;
        Start    = 1'b0;
        MCycleOp = 1'b0;
        Operand1 = '0;
        Operand2 = '0;
        #2;
        total_cnt++;
        if ({Busy, done, Result1, Result2} !== 66'd0)
            $display("FAIL reset_initial: busy=%b done=%b r1=%h r2=%h, required all zero",
                     Busy, done, Result1, Result2);
        else pass_cnt++;
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_op(1'b0, 32'd3, 32'd5, cyc, bsy, to);
        total_cnt++;
        if (to || Result1 !== 32'd15 || Result2 !== 32'd0)
            $display("FAIL reset_preload: timeout=%0d r1=%0d r2=%0d, required 15 0", to, Result1, Result2);
        else pass_cnt++;

        MCycleOp = 1'b0;
        Operand1 = 32'h0001_0000;
        Operand2 = 32'h0001_0000;
        Start    = 1'b1;
        repeat (10) tick();
        total_cnt++;
        if (Busy !== 1'b1)
            $display("FAIL reset_midrun_busy: busy=%b, required 1", Busy);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({Busy, done, Result1, Result2} !== 66'd0)
            $display("FAIL reset_async: busy=%b done=%b r1=%h r2=%h, required all zero",
                     Busy, done, Result1, Result2);
        else pass_cnt++;
        Start = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        total_cnt++;
        if (Busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_idle_after: busy=%b done=%b, required 0 0", Busy, done);
        else pass_cnt++;
    endtask

    task automatic test_mul_max();
        int cyc, bsy;
        bit to;
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bsy, to);
        total_cnt++;
        if (to || Result1 !== 32'h0000_0001 || Result2 !== 32'hFFFF_FFFE)
            $display("FAIL mul_max: r2=%h r1=%h, required fffffffe 00000001", Result2, Result1);
        else pass_cnt++;
        total_cnt++;
        if (cyc !== 33)
            $display("FAIL mul_latency: done after %0d cycles, required 33", cyc);
        else pass_cnt++;
        total_cnt++;
        if (bsy !== 32)
            $display("FAIL mul_busy_len: busy for %0d cycles, required 32", bsy);
        else pass_cnt++;
    endtask

    task automatic test_div();
        int cyc, bsy;
        bit to;
        run_op(1'b1, 32'd100, 32'd7, cyc, bsy, to);
        total_cnt++;
        if (to || Result1 !== 32'd14 || Result2 !== 32'd2)
            $display("FAIL div_100_7: q=%0d r=%0d, required 14 2", Result1, Result2);
        else pass_cnt++;
        run_op(1'b1, 32'h8000_0000, 32'd1, cyc, bsy, to);
        total_cnt++;
        if (to || Result1 !== 32'h8000_0000 || Result2 !== 32'd0)
            $display("FAIL div_msb_1: q=%h r=%h, required 80000000 0", Result1, Result2);
        else pass_cnt++;
    endtask

    task automatic test_div_zero();
        int cyc, bsy;
        bit to;
        run_op(1'b1, 32'h0000_1234, 32'd0, cyc, bsy, to);
        total_cnt++;
        if (to)
            $display("FAIL div_zero_hang: done not seen within %0d cycles, required 33", cyc);
        else pass_cnt++;
        total_cnt++;
        if (Result1 !== 32'hFFFF_FFFF || Result2 !== 32'h0000_1234)
            $display("FAIL div_zero: q=%h r=%h, required ffffffff 00001234", Result1, Result2);
        else pass_cnt++;
    endtask

    task automatic test_handshake();
        int cyc, bsy, n;
        bit to;
        MCycleOp = 1'b0;
        Operand1 = 32'd7;
        Operand2 = 32'd9;
        Start    = 1'b1;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        total_cnt++;
        if (done !== 1'b1)
            $display("FAIL hs_first_done: done=%b after %0d cycles, required 1", done, n);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++;
            if (done !== 1'b1 || Busy !== 1'b0 || Result1 !== 32'd63)
                $display("FAIL hs_hold_%0d: done=%b busy=%b r1=%0d, required 1 0 63",
                         i, done, Busy, Result1);
            else pass_cnt++;
        end
        Start = 1'b0;
        tick();
        total_cnt++;
        if (done !== 1'b0 || Busy !== 1'b0)
            $display("FAIL hs_release: done=%b busy=%b, required 0 0", done, Busy);
        else pass_cnt++;
        run_op(1'b0, 32'd3, 32'd5, cyc, bsy, to);
        total_cnt++;
        if (to || cyc !== 33 || Result1 !== 32'd15 || Result2 !== 32'd0)
            $display("FAIL hs_back_to_back: cycles=%0d r1=%0d r2=%0d, required 33 15 0",
                     cyc, Result1, Result2);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        bit seen_done;
        MCycleOp = 1'b1;
        Operand1 = 32'd1000;
        Operand2 = 32'd3;
        Start    = 1'b1;
        repeat (12) tick();
        Start = 1'b0;
        tick();
        total_cnt++;
        if (Busy !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_idle: busy=%b done=%b, required 0 0", Busy, done);
        else pass_cnt++;
        seen_done = 1'b0;
        repeat (40) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        total_cnt++;
        if (seen_done)
            $display("FAIL abort_no_done: done=1 seen, required never");
        else pass_cnt++;
        total_cnt++;
        if (Result1 !== 32'd15 || Result2 !== 32'd0)
            $display("FAIL abort_results: r1=%0d r2=%0d, required 15 0", Result1, Result2);
        else pass_cnt++;
    endtask

    task automatic test_operand_change();
        int n;
        MCycleOp = 1'b0;
        Operand1 = 32'd6;
        Operand2 = 32'd7;
        Start    = 1'b1;
        repeat (3) tick();
        MCycleOp = 1'b1;
        Operand1 = 32'hFFFF_FFFF;
        Operand2 = 32'h0000_1234;
        n = 3;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        total_cnt++;
        if (done !== 1'b1 || Result1 !== 32'd42 || Result2 !== 32'd0)
            $display("FAIL operand_change: done=%b r1=%0d r2=%0d, required 1 42 0",
                     done, Result1, Result2);
        else pass_cnt++;
        Start = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int          cyc, bsy;
        bit          to;
        logic        op;
        logic [31:0] a, b, exp1, exp2;
        logic [63:0] prod;
        for (int i = 0; i < 40; i++) begin
            op = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            if (op && (i % 4 == 0)) b = $urandom_range(1, 255);
            if (!op) begin
                prod = 64'(a) * 64'(b);
                exp1 = prod[31:0];
                exp2 = prod[63:32];
            end else if (b == 0) begin
                exp1 = 32'hFFFF_FFFF;
                exp2 = a;
            end else begin
                exp1 = a / b;
                exp2 = a % b;
            end
            run_op(op, a, b, cyc, bsy, to);
            total_cnt++;
            if (to || Result1 !== exp1 || Result2 !== exp2)
                $display("FAIL random_%0d op=%0d a=%h b=%h: r1=%h r2=%h, required %h %h",
                         i, op, a, b, Result1, Result2, exp1, exp2);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_mul_max();
        test_div();
        test_div_zero();
        test_handshake();
        test_abort();
        test_operand_change();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
